// File: rtl/throbber_if.sv
// throbber_if: per-channel control inputs and registered LED/tick outputs of the throbber.
interface throbber_if #(
    parameter int CHANNELS     = 4,
    parameter int PERIOD_WIDTH = 24
);
    logic [CHANNELS-1:0]     enable;
    logic [2*CHANNELS-1:0]   mode;
    logic [PERIOD_WIDTH-1:0] half_period;
    logic                    sync_pulse;
    logic [CHANNELS-1:0]     led;
    logic                    tick;
    modport master (output enable, mode, half_period, sync_pulse, input led, tick);
    modport slave  (input enable, mode, half_period, sync_pulse, output led, tick);
endinterface

// File: rtl/throbber.sv
// throbber: multi-channel LED driver (off/steady/blink/breathe) paced by one shared prescaler.
module throbber #(
    parameter int CHANNELS     = 4,
    parameter int PERIOD_WIDTH = 24,
    parameter int PWM_BITS     = 8
) (
    input logic       clock,
    input logic       reset,
    throbber_if.slave bus
);
    typedef enum logic {UP, DOWN} dir_e;
    localparam logic [PWM_BITS-1:0]     MAX   = '1;
    localparam logic [PWM_BITS-1:0]     ONE_L = PWM_BITS'(1);
    localparam logic [PERIOD_WIDTH-1:0] ONE_C = PERIOD_WIDTH'(1);
    logic [PERIOD_WIDTH-1:0] count_q, count_d;
    logic [PWM_BITS-1:0]     pwm_q, pwm_d;
    logic                    tick_q, tick_d;
    logic [CHANNELS-1:0]     blink_q, blink_d, led_q, led_d;
    logic [PWM_BITS-1:0]     level_q [CHANNELS];
    logic [PWM_BITS-1:0]     level_d [CHANNELS];
    dir_e                    dir_q [CHANNELS];
    dir_e                    dir_d [CHANNELS];
    logic [CHANNELS-1:0]     clr, turn, rise;
    logic                    wrap;
    always_comb begin
        wrap    = count_q >= bus.half_period;
        count_d = (wrap || bus.sync_pulse) ? '0 : count_q + ONE_C;
        tick_d  = wrap && !bus.sync_pulse;
        pwm_d   = bus.sync_pulse ? '0 : pwm_q + ONE_L;
        for (int i = 0; i < CHANNELS; i++) begin
            clr[i]  = !bus.enable[i] || bus.sync_pulse;
            // a ramp turns around at either end; it then steps away from that end
            turn[i] = (dir_q[i] == UP) ? (level_q[i] == MAX) : (level_q[i] == '0);
            rise[i] = (dir_q[i] == UP) ^ turn[i];
            blink_d[i] = clr[i] ? 1'b0 : blink_q[i] ^ wrap;
            level_d[i] = clr[i] ? '0 : !wrap ? level_q[i] :
                         rise[i] ? level_q[i] + ONE_L : level_q[i] - ONE_L;
            dir_d[i]   = clr[i] ? UP : !(wrap && turn[i]) ? dir_q[i] :
                         (dir_q[i] == UP) ? DOWN : UP;
            led_d[i]   = !bus.enable[i] ? 1'b0 :
                         bus.mode[2*i +: 2] == 2'b00 ? 1'b0 :
                         bus.mode[2*i +: 2] == 2'b01 ? 1'b1 :
                         bus.mode[2*i +: 2] == 2'b10 ? blink_q[i] :
                         level_q[i] > pwm_q;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            blink_q <= '0;
            led_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= '0;
                dir_q[i]   <= UP;
            end
        end else begin
            count_q <= count_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            led_q   <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= level_d[i];
                dir_q[i]   <= dir_d[i];
            end
        end
    end
    assign bus.led  = led_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_throbber.sv
// tb_throbber: directed vectors push expected tick/led per cycle; a monitor pops and compares.
module tb_throbber;
    localparam int CH = 4;
    localparam int PW = 24;
    localparam int PB = 3;
    typedef struct {
        int              id;
        logic            tc;
        logic            t;
        logic [CH-1:0]   lm;
        logic [CH-1:0]   l;
    } exp_t;
    logic clock = 1'b0;
    logic reset;
    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    always #5 clock = ~clock;
    throbber_if #(.CHANNELS(CH), .PERIOD_WIDTH(PW)) bus ();
    throbber #(.CHANNELS(CH), .PERIOD_WIDTH(PW), .PWM_BITS(PB)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            if (mon_e.tc) begin
                checks++;
                if (bus.tick !== mon_e.t) begin
                    errors++;
                    $display("FAIL tick vec %0d: got %b want %b", mon_e.id, bus.tick, mon_e.t);
                end
            end
            if (mon_e.lm != '0) begin
                checks++;
                if ((bus.led & mon_e.lm) !== (mon_e.l & mon_e.lm)) begin
                    errors++;
                    $display("FAIL led vec %0d: got %b want %b (mask %b)", mon_e.id, bus.led,
                             mon_e.l, mon_e.lm);
                end
            end
        end
    end
    task automatic cyc(input logic t, input logic [CH-1:0] l);
        exp_t e;
        e.id = vec_id;
        e.tc = 1'b1;
        e.t  = t;
        e.lm = '1;
        e.l  = l;
        vec_id++;
        q.push_back(e);
        @(negedge clock);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, '0);
        reset = 1'b0;
    endtask
    initial begin
        logic [CH-1:0] l;
        int            w;
        int            lev;
        reset           = 1'b1;
        bus.enable      = '0;
        bus.mode        = '0;
        bus.half_period = 3;
        bus.sync_pulse  = 1'b0;
        @(negedge clock);
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        // blink on ch0, tick every 4 clocks, LED period 8
        reset    = 1'b0;
        bus.mode   = 8'b00_00_00_10;
        bus.enable = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            l = '0;
            l[0] = ((k - 1) / 4) % 2 == 1;
            cyc(k % 4 == 0, l);
        end
        // half_period 0: tick held high, blink toggles every clock
        bus.half_period = 0;
        for (int j = 0; j < 6; j++) begin
            l = '0;
            l[0] = j % 2 == 1;
            cyc(1'b1, l);
        end
        bus.half_period = 2;
        for (int m = 1; m <= 9; m++) begin
            l = '0;
            l[0] = ((m - 1) / 3) % 2 == 1;
            cyc(m % 3 == 0, l);
        end
        // staggered enable: ch2 joins after 5 ticks, opposite phase to ch0
        do_reset();
        bus.half_period = 1;
        bus.mode        = 8'b00_10_00_10;
        bus.enable      = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            if (k == 11) bus.enable = 4'b0101;
            l = '0;
            l[0] = ((k - 1) / 2) % 2 == 1;
            l[2] = k >= 13 && ((k - 13) / 2) % 2 == 0;
            cyc(k % 2 == 0, l);
        end
        // sync_pulse coincident with the second wrap
        do_reset();
        bus.half_period = 3;
        bus.mode        = 8'b00_00_00_10;
        bus.enable      = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            bus.sync_pulse = k == 8;
            l = '0;
            l[0] = (k >= 5 && k <= 8) || k >= 13;
            cyc(k == 4 || k == 12, l);
        end
        bus.sync_pulse = 1'b0;
        // breathe on ch1: tick period equals PWM period, so level L lights L of 8 clocks
        do_reset();
        bus.half_period = 7;
        bus.mode        = 8'b00_00_11_00;
        bus.enable      = 4'b0010;
        for (int k = 1; k <= 128; k++) begin
            w   = (k - 1) / 8;
            lev = w <= 7 ? w : w <= 14 ? 14 - w : w - 14;
            l = '0;
            l[1] = ((k - 1) % 8) < lev;
            cyc(k % 8 == 0, l);
        end
        // reset mid-ramp on ch3, then steady/off/breathe from a clean start
        do_reset();
        bus.half_period = 0;
        bus.mode        = 8'b11_00_00_00;
        bus.enable      = 4'b1000;
        for (int k = 1; k <= 5; k++) cyc(1'b1, '0);
        reset = 1'b1;
        cyc(1'b0, '0);
        cyc(1'b0, '0);
        reset           = 1'b0;
        bus.half_period = 3;
        bus.mode        = 8'b11_00_01_00;
        bus.enable      = 4'b1011;
        for (int k = 1; k <= 12; k++) begin
            l = 4'b0010;
            l[3] = k == 9 || k == 10;
            cyc(k % 4 == 0, l);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/throbber.md
# throbber

Parametrised multi-channel LED status generator, successor to the single hard-coded throb counter in the top level. One shared prescaler produces a tick every `half_period+1` clocks. Each channel independently drives its LED as off, steady, blinking, or PWM "breathing" with a triangular duty ramp. Sits beside the UART/rot13 path in board top-levels and drives `chan[]` LED pins.

## Interface
- `CHANNELS`, 4: number of LED channels (≥1)
- `PERIOD_WIDTH`, 24: width of prescaler counter and `half_period`
- `PWM_BITS`, 8: PWM resolution (≥1); `MAX` = 2^PWM_BITS−1

Ports:
- `clock`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `enable`  in  CHANNELS  per-channel enable; low holds that channel's state at reset values
- `mode`  in  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 steady on, 10 blink, 11 breathe
- `half_period`  in  PERIOD_WIDTH  prescaler terminal count; tick period = half_period+1 clocks
- `sync_pulse`  in  1  one-cycle restart of prescaler, PWM counter and all channel states
- `led`  out  CHANNELS  registered LED drive
- `tick`  out  1  registered one-cycle strobe per prescaler wrap

## Operation
- Prescaler `count` (PERIOD_WIDTH): wrap condition is `count >= half_period`. On wrap: `count<=0`, `tick<=1`. Otherwise `count<=count+1`, `tick<=0`.
- `half_period=0` gives wrap every cycle, so `tick` is held high.
- `half_period` lowered below the current `count`: wrap occurs on the next edge. No overflow is possible.
- PWM counter `pwm_cnt` (PWM_BITS): free-running +1 per clock, wraps MAX→0. Shared by all channels.
- Per-channel state: `blink` (1 b), `level` (PWM_BITS), `dir` (0=up, 1=down). State advances on wrap whenever `enable[i]=1`, independent of mode, so switching mode does not reset phase.
  - blink: toggles on each wrap.
  - ramp, dir up: `level==MAX` → `dir<=down`, `level<=MAX−1`; else `level+1`.
  - ramp, dir down: `level==0` → `dir<=up`, `level<=1`; else `level−1`.
  - PWM_BITS=1 special case: MAX=1, so the ramp alternates 0,1,0,1.
  - Triangle period = 2·MAX ticks.
- `enable[i]=0`: `blink=0`, `level=0`, `dir=up`, `led[i]<=0`. A rising enable starts that channel from the beginning, so staggered enables give staggered phases.
- LED select, registered every clock:
  - off → 0
  - steady → 1
  - blink → `blink`
  - breathe → `level > pwm_cnt`, giving duty level/2^PWM_BITS; `level=0` is fully dark.
- `sync_pulse`: `count<=0`, `pwm_cnt<=0`, all channel states to reset values, `tick<=0`. No wrap is processed that cycle. `sync_pulse` has priority over a coincident wrap. `led` follows the cleared state on the next edge.
- `reset`: highest priority. Clears all of the above. `led=0` and `tick=0` while reset is asserted and on the first edge after it.

## Timing
- Wrap decision and channel-state update occur on the same edge that asserts `tick`.
- `led` reflects updated state one clock later, i.e. the LED changes one cycle after `tick` rises.
- `mode` and `enable` changes reach `led` after 1 clock.
- `half_period` is sampled every clock; there is no shadow register.
- Steady state after reset release with `half_period=N`: first `tick` asserts N+1 clocks after reset deasserts (count goes 0..N). Thereafter one tick every N+1 clocks.
- Reset mid-operation: all state is cleared on that edge with no partial update. After release, behaviour is identical to power-up.

## Test plan
- Blink timing: CHANNELS=4, `half_period=3`, ch0 mode 10, enable=1 → `tick` every 4 clocks. `led[0]` toggles 1 clock after each tick, giving an 8-clock period with 50% duty.
- Breathe duty: PWM_BITS=2, `half_period=7`, ch1 mode 11 → `level` sequence per tick is 1,2,3,2,1,0,1… `led[1]` high 1,2,3 of every 4 clocks for levels 1,2,3, and never high at level 0.
- `half_period=0` → `tick` held high. Blink LED toggles every clock. Then set `half_period=2` while `count` is 0 → ticks every 3 clocks.
- Staggered enable: enable ch0, wait 5 ticks, enable ch2, both in blink → ch2 starts at 0 on enable, ch0 continues. Both toggle on the same edges thereafter.
- `sync_pulse` coincident with wrap → no `tick` that cycle, all `blink`/`level` cleared. Next tick arrives `half_period+1` clocks later.
- Reset mid-ramp (ch3 breathe, `level=5`) → `led=0` and `tick=0` on the next edge. After release `level` restarts from 0 with dir up; modes 00 and 01 give constant 0 and 1.
